// File: rtl/cmos_comparator_4bit.sv
// Two-stage unsigned magnitude comparator with cascade inputs.
// MSB-first slice cascade, registered inputs and registered result.
module cmos_comparator_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             casc_lt,
    input  logic             casc_gt,
    input  logic             casc_eq,
    output logic             out_valid,
    output logic             a_lt_b,
    output logic             a_gt_b,
    output logic             a_eq_b
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             lt_q;
    logic             gt_q;
    logic             eq_q;
    logic             vld_q;

    logic [WIDTH-1:0] bit_lt;
    logic [WIDTH-1:0] bit_gt;
    logic [WIDTH-1:0] bit_eq;

    logic             cmp_lt;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             res_lt;
    logic             res_gt;
    logic             res_eq;

    // Stage 1: capture operands and cascade code every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            lt_q  <= 1'b0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            lt_q  <= casc_lt;
            gt_q  <= casc_gt;
            eq_q  <= casc_eq;
            vld_q <= in_valid;
        end
    end

    assign bit_lt = ~a_q & b_q;
    assign bit_gt = a_q & ~b_q;
    assign bit_eq = ~(bit_lt | bit_gt);

    // Walk slices MSB first; the first unequal slice decides.
    always_comb begin
        logic pre;
        pre    = 1'b1;
        cmp_lt = 1'b0;
        cmp_gt = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cmp_lt = cmp_lt | (pre & bit_lt[i]);
            cmp_gt = cmp_gt | (pre & bit_gt[i]);
            pre    = pre & bit_eq[i];
        end
        cmp_eq = pre;
    end

    // Equal operands defer to the lower-significance cascade code.
    always_comb begin
        res_lt = cmp_lt;
        res_gt = cmp_gt;
        res_eq = 1'b0;
        if (cmp_eq) begin
            res_lt = lt_q;
            res_gt = gt_q;
            res_eq = eq_q;
        end
    end

    // Stage 2: register the resolved result and its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_lt_b    <= 1'b0;
            a_gt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
        end else begin
            out_valid <= vld_q;
            a_lt_b    <= res_lt;
            a_gt_b    <= res_gt;
            a_eq_b    <= res_eq;
        end
    end

endmodule

// File: tb/tb_cmos_comparator_4bit.sv
// Directed bench for cmos_comparator_4bit.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_cmos_comparator_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       casc_lt;
    logic       casc_gt;
    logic       casc_eq;
    logic       out_valid;
    logic       a_lt_b;
    logic       a_gt_b;
    logic       a_eq_b;

    int n_cmp;
    int n_bad;

    cmos_comparator_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .casc_lt   (casc_lt),
        .casc_gt   (casc_gt),
        .casc_eq   (casc_eq),
        .out_valid (out_valid),
        .a_lt_b    (a_lt_b),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [2:0] res);
        chk({tag, ".vld"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".res"}, {29'd0, a_lt_b, a_gt_b, a_eq_b},
            {29'd0, res});
    endtask

    // Issue one compare, check its result two edges later.
    task automatic run(input string tag, input logic [3:0] va,
                       input logic [3:0] vb, input logic [2:0] casc,
                       input logic [2:0] res);
        a        = va;
        b        = vb;
        {casc_lt, casc_gt, casc_eq} = casc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk_out(tag, 1'b1, res);
    endtask

    logic [2:0] exp_res [0:255];

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'hF;
        b        = 4'h0;
        casc_lt  = 1'b0;
        casc_gt  = 1'b0;
        casc_eq  = 1'b1;

        tick();
        tick();
        chk_out("reset", 1'b0, 3'b000);

        rst_n = 1'b1;
        tick();
        chk("rel.e1", {31'd0, out_valid}, 32'd0);
        tick();
        chk_out("rel.e2", 1'b1, 3'b010);
        in_valid = 1'b0;
        tick();
        tick();
        chk("idle", {31'd0, out_valid}, 32'd0);

        run("msb.gt", 4'b1000, 4'b0111, 3'b001, 3'b010);
        run("msb.lt", 4'b0111, 4'b1000, 3'b001, 3'b100);
        run("lsb.lt", 4'b0110, 4'b0111, 3'b001, 3'b100);
        run("lsb.gt", 4'b1011, 4'b1010, 3'b001, 3'b010);
        run("eq.eq",  4'h9, 4'h9, 3'b001, 3'b001);
        run("eq.clt", 4'h9, 4'h9, 3'b100, 3'b100);
        run("eq.cgt", 4'h9, 4'h9, 3'b010, 3'b010);
        run("ne.casc", 4'h3, 4'h9, 3'b010, 3'b100);
        run("eq.bad", 4'h5, 4'h5, 3'b110, 3'b110);
        run("w.0", 4'h0, 4'h0, 3'b001, 3'b001);
        run("w.f0", 4'hF, 4'h0, 3'b001, 3'b010);
        run("w.0f", 4'h0, 4'hF, 3'b001, 3'b100);

        for (int k = 0; k < 256; k++) begin
            if ((k >> 4) < (k & 15))
                exp_res[k] = 3'b100;
            else if ((k >> 4) > (k & 15))
                exp_res[k] = 3'b010;
            else
                exp_res[k] = 3'b001;
        end

        casc_lt = 1'b0;
        casc_gt = 1'b0;
        casc_eq = 1'b1;
        for (int k = 0; k < 258; k++) begin
            if (k >= 2) begin
                chk_out("sweep", 1'b1, exp_res[k-2]);
                chk("onehot",
                    {30'd0, 2'(a_lt_b + a_gt_b + a_eq_b)}, 32'd1);
            end
            if (k < 256) begin
                a        = 4'(k >> 4);
                b        = 4'(k & 15);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        chk("sweep.end", {31'd0, out_valid}, 32'd0);

        a        = 4'h2;
        b        = 4'h1;
        in_valid = 1'b1;
        tick();
        tick();
        chk_out("pre.rst", 1'b1, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async", 1'b0, 3'b000);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        chk("stale.1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("stale.2", {31'd0, out_valid}, 32'd0);
        tick();
        chk("stale.3", {31'd0, out_valid}, 32'd0);

        run("post.rst", 4'h4, 4'h6, 3'b001, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmos_comparator_4bit.md
Name: cmos_comparator_4bit

Overview:
Pipelined unsigned magnitude comparator for two WIDTH-bit operands A and B. It reports exactly one of A<B, A>B or A==B.
The compare is an MSB-first cascade of per-bit slices. Each slice produces bit_lt = ~a&b, bit_gt = a&~b and bit_eq = ~(bit_lt|bit_gt).
It sits in datapath control logic as a registered two-stage block with valid tracking, and accepts one compare per clock.
Cascade inputs allow wider comparators to be built by chaining instances.

Parameters:
WIDTH, 4, operand width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  A, B and the cascade inputs are valid this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
casc_lt  input  1  lower-significance result "A<B", used only when a==b
casc_gt  input  1  lower-significance result "A>B", used only when a==b
casc_eq  input  1  lower-significance result "A==B"; tie to 1 (with casc_lt=casc_gt=0) when unused
out_valid  output  1  result outputs are valid
a_lt_b  output  1  A less than B (AiB)
a_gt_b  output  1  A greater than B (AsB)
a_eq_b  output  1  A equal to B (AeB)

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n=0 immediately clears, without waiting for a clock edge:
  - the stage-1 registers (a, b, cascade inputs, valid);
  - out_valid, a_lt_b, a_gt_b and a_eq_b, all to 0.
- Stage 1: on each rising clk, capture a, b, casc_* and in_valid. Capture is unconditional; the valid bit qualifies the data.
- Stage 2 combinational logic, for slice i (WIDTH-1 down to 0):
  - lt_i = ~a[i]&b[i]; gt_i = a[i]&~b[i]; eq_i = ~(lt_i|gt_i).
  - prefix_eq_i = AND of eq_j for all j>i; prefix_eq for the MSB slice = 1.
  - LT = OR over i of (prefix_eq_i & lt_i); GT = OR over i of (prefix_eq_i & gt_i); EQ_ab = AND of all eq_i.
- Cascade resolution:
  - EQ_ab=0: outputs are {LT, GT, 0}.
  - EQ_ab=1: outputs are {casc_lt, casc_gt, casc_eq}.
  - Illegal cascade codes pass through unchanged when a==b. The block does not check them.
- Stage 2 register: on each rising clk, a_lt_b/a_gt_b/a_eq_b <= resolved values and out_valid <= stage-1 valid.
- Latency is 2 cycles from the in_valid sample to the out_valid assertion. Throughput is 1 per cycle. There is no backpressure.
- Outputs update every cycle. When out_valid=0 the result bits are don't-care for consumers, but they must still be a deterministic function of the captured data.
- Invariant: with a legal cascade code, and out_valid=1, exactly one of a_lt_b/a_gt_b/a_eq_b is 1.
- Reset asserted mid-pipeline discards all in-flight compares. After rst_n deasserts, the first valid result appears 2 cycles after the first sampled in_valid=1.
- Operands are strictly unsigned. There is no sign handling and no X-propagation requirement.
- A back-to-back change of a and b on consecutive cycles yields independent results on consecutive cycles.

Test Plan:
- Reset: hold rst_n=0 while driving a=4'hF, b=4'h0, in_valid=1 -> all outputs 0. Release rst_n -> out_valid rises 2 cycles after the first post-reset in_valid sample.
- MSB decides: a=4'b1000, b=4'b0111, casc_eq=1 -> after 2 cycles a_gt_b=1, a_lt_b=0, a_eq_b=0. Swap operands -> a_lt_b=1.
- LSB decides: a=4'b0110, b=4'b0111 -> a_lt_b=1. Then a=4'b1011, b=4'b1010 -> a_gt_b=1.
- Equality and cascade, with a=b=4'h9:
  - casc={lt=0,gt=0,eq=1} -> a_eq_b=1;
  - casc={lt=1,gt=0,eq=0} -> a_lt_b=1;
  - casc={lt=0,gt=1,eq=0} -> a_gt_b=1.
- Exhaustive sweep: all 256 (a,b) pairs with casc_eq=1, issued back-to-back with in_valid=1 -> every out_valid cycle matches the unsigned compare and the one-hot invariant holds.
- Async reset mid-stream: pulse rst_n low between clock edges while out_valid=1 -> outputs clear immediately. No stale result appears after release.
